// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: issues word fetches, buffers returned words with their next-PC
// in a small FIFO, and hands them to ID over valid/ready. A redirect flushes everything in flight.
module mips32_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  output logic                         imem_req,
  output logic [AW-1:0]                imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         halt,
  output logic                         id_valid,
  output logic [31:0]                  id_ir,
  output logic [31:0]                  id_npc,
  input  logic                         id_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rptr_q, wptr_q;
  logic [31:0]   ir_mem_q  [DEPTH];
  logic [31:0]   npc_mem_q [DEPTH];
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check counts the in-flight word so a response always has a free slot.
  assign imem_req  = rst_n & ~redirect & ~halt &
                     ((32'(count_q) + 32'(inflight_q)) < DEPTH);
  assign imem_addr = pc_q[AW-1:0];

  assign id_valid  = (count_q != '0);
  assign push      = inflight_q & ~redirect;
  assign pop       = id_valid & id_ready & ~redirect;

  assign id_ir     = id_valid ? ir_mem_q[rptr_q]  : '0;
  assign id_npc    = id_valid ? npc_mem_q[rptr_q] : '0;
  assign occupancy = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
    end else if (redirect) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        pc_q          <= pc_q + 32'd1;
        inflight_pc_q <= pc_q;
      end
      count_q <= count_d;
      if (push) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= '0;
        npc_mem_q[i] <= '0;
      end
    end else if (push) begin
      ir_mem_q[wptr_q]  <= imem_rdata;
      npc_mem_q[wptr_q] <= inflight_pc_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: directed vector table, async-reset sequence, and random
// traffic checked against a queue-based reference model.
module tb_mips32_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          halt = 1'b0;
  logic          id_valid;
  logic [31:0]   id_ir;
  logic [31:0]   id_npc;
  logic          id_ready = 1'b0;
  logic [2:0]    occupancy;

  int tests = 0;
  int fails = 0;

  mips32_fetch_queue #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .RESET_PC(32'h0)
  ) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .id_valid   (id_valid),
    .id_ir      (id_ir),
    .id_npc     (id_npc),
    .id_ready   (id_ready),
    .occupancy  (occupancy)
  );

  always #5 clk1 = ~clk1;

  // Memory word k holds 0x1000 + k; data returns one cycle after the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + {22'b0, a[AW-1:0]};
  endfunction

  always_ff @(posedge clk1) imem_rdata <= mem_word({22'b0, imem_addr});

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        hlt;
    logic        rdr;
    logic [31:0] rpc;
    logic [31:0] ev;
    logic [31:0] eir;
    logic [31:0] enpc;
    logic [31:0] eocc;
    logic [31:0] ereq;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic hlt, input logic rdr,
                              input logic [31:0] rpc, input logic [31:0] ev,
                              input logic [31:0] eir, input logic [31:0] enpc,
                              input logic [31:0] eocc, input logic [31:0] ereq,
                              input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.hlt = hlt; v.rdr = rdr; v.rpc = rpc; v.ev = ev;
    v.eir = eir; v.enpc = enpc; v.eocc = eocc; v.ereq = ereq; v.eaddr = eaddr;
    return v;
  endfunction

  // Reference model: a plain queue of {ir, npc} plus the outstanding fetch.
  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_infl;
  logic [31:0] m_infl_pc;

  task automatic model_reset();
    mq.delete();
    m_pc      = 32'h0;
    m_infl    = 1'b0;
    m_infl_pc = 32'h0;
  endtask

  function automatic logic model_req();
    return !redirect && !halt && (mq.size() + int'(m_infl) < int'(DEPTH));
  endfunction

  task automatic model_check(input int cyc);
    logic        v;
    logic [31:0] eir, enpc;
    v    = (mq.size() != 0);
    eir  = v ? mq[0].ir  : 32'h0;
    enpc = v ? mq[0].npc : 32'h0;
    check("rnd_valid", cyc, 32'(id_valid), 32'(v));
    check("rnd_ir",    cyc, id_ir, eir);
    check("rnd_npc",   cyc, id_npc, enpc);
    check("rnd_occ",   cyc, 32'(occupancy), 32'(mq.size()));
    check("rnd_req",   cyc, 32'(imem_req), 32'(model_req()));
    check("rnd_addr",  cyc, 32'(imem_addr), {22'b0, m_pc[AW-1:0]});
  endtask

  task automatic model_step();
    logic req;
    ent_t e;
    req = model_req();
    if (redirect) begin
      mq.delete();
      m_infl = 1'b0;
      m_pc   = redirect_pc;
    end else begin
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (m_infl) begin
        e.ir  = mem_word(m_infl_pc);
        e.npc = m_infl_pc + 32'd1;
        mq.push_back(e);
      end
      m_infl = req;
      if (req) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd1;
      end
    end
  endtask

  vec_t tbl[27];

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
    tbl[2]  = mk(1, 0, 0, 0, 1, 32'h1000, 32'h1, 1, 1, 32'h2);
    tbl[3]  = mk(1, 0, 0, 0, 1, 32'h1001, 32'h2, 1, 1, 32'h3);
    tbl[4]  = mk(1, 0, 0, 0, 1, 32'h1002, 32'h3, 1, 1, 32'h4);
    tbl[5]  = mk(0, 0, 0, 0, 1, 32'h1003, 32'h4, 1, 1, 32'h5);
    tbl[6]  = mk(0, 0, 0, 0, 1, 32'h1003, 32'h4, 2, 1, 32'h6);
    tbl[7]  = mk(0, 0, 0, 0, 1, 32'h1003, 32'h4, 3, 0, 32'h7);
    tbl[8]  = mk(0, 0, 0, 0, 1, 32'h1003, 32'h4, 4, 0, 32'h7);
    tbl[9]  = mk(1, 0, 0, 0, 1, 32'h1003, 32'h4, 4, 0, 32'h7);
    tbl[10] = mk(1, 0, 0, 0, 1, 32'h1004, 32'h5, 3, 1, 32'h7);
    tbl[11] = mk(1, 0, 0, 0, 1, 32'h1005, 32'h6, 2, 1, 32'h8);
    tbl[12] = mk(1, 0, 0, 0, 1, 32'h1006, 32'h7, 2, 1, 32'h9);
    // Redirect with two queued, one in flight, and a pop offered.
    tbl[13] = mk(1, 0, 1, 32'h40, 1, 32'h1007, 32'h8, 2, 0, 32'hA);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h41);
    tbl[16] = mk(1, 0, 0, 0, 1, 32'h1040, 32'h41, 1, 1, 32'h42);
    tbl[17] = mk(0, 1, 0, 0, 1, 32'h1041, 32'h42, 1, 0, 32'h43);
    tbl[18] = mk(0, 1, 0, 0, 1, 32'h1041, 32'h42, 2, 0, 32'h43);
    tbl[19] = mk(0, 0, 0, 0, 1, 32'h1041, 32'h42, 2, 1, 32'h43);
    tbl[20] = mk(1, 0, 0, 0, 1, 32'h1041, 32'h42, 2, 1, 32'h44);
    tbl[21] = mk(1, 0, 0, 0, 1, 32'h1042, 32'h43, 2, 1, 32'h45);
    // Redirect while halted, to the last word address.
    tbl[22] = mk(1, 1, 1, 32'hFFFF_FFFF, 1, 32'h1043, 32'h44, 2, 0, 32'h46);
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3FF);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    tbl[25] = mk(1, 0, 0, 0, 1, 32'h13FF, 32'h0, 1, 1, 32'h1);
    tbl[26] = mk(1, 0, 0, 0, 1, 32'h1000, 32'h1, 1, 1, 32'h2);

    // Outputs while reset is held.
    repeat (3) @(negedge clk1);
    #1;
    check("rst_valid", 0, 32'(id_valid), 32'h0);
    check("rst_req",   0, 32'(imem_req), 32'h0);
    check("rst_occ",   0, 32'(occupancy), 32'h0);

    @(negedge clk1);
    rst_n = 1'b1;
    for (int i = 0; i < 27; i++) begin
      id_ready    = tbl[i].rdy;
      halt        = tbl[i].hlt;
      redirect    = tbl[i].rdr;
      redirect_pc = tbl[i].rpc;
      #1;
      check("tbl_valid", i, 32'(id_valid), tbl[i].ev);
      check("tbl_ir",    i, id_ir, tbl[i].eir);
      check("tbl_npc",   i, id_npc, tbl[i].enpc);
      check("tbl_occ",   i, 32'(occupancy), tbl[i].eocc);
      check("tbl_req",   i, 32'(imem_req), tbl[i].ereq);
      check("tbl_addr",  i, 32'(imem_addr), tbl[i].eaddr);
      @(negedge clk1);
    end

    // Fill to three entries, then drop reset asynchronously between edges.
    id_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    #1;
    check("arst0_occ", 0, 32'(occupancy), 32'h0);
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk1);
    #1;
    check("fill_occ", 0, 32'(occupancy), 32'h3);
    check("fill_ir",  0, id_ir, 32'h1000);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 1, 32'(id_valid), 32'h0);
    check("arst_ir",    1, id_ir, 32'h0);
    check("arst_npc",   1, id_npc, 32'h0);
    check("arst_occ",   1, 32'(occupancy), 32'h0);
    check("arst_req",   1, 32'(imem_req), 32'h0);
    @(negedge clk1);
    rst_n = 1'b1;
    #1;
    check("restart_req",  0, 32'(imem_req), 32'h1);
    check("restart_addr", 0, 32'(imem_addr), 32'h0);

    // Random traffic against the reference model.
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      id_ready    = ($urandom_range(0, 3) != 0);
      halt        = ($urandom_range(0, 7) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                : $urandom;
      #1;
      model_check(c);
      model_step();
      @(negedge clk1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/mips32_fetch_queue.md
# mips32_fetch_queue

Instruction-fetch front end for the pipelined mips32 core. Generates word addresses into instruction memory, captures returned words into a small prefetch FIFO tagged with their next-PC, and presents them to the ID stage over a valid/ready handshake. Sits directly upstream of the IF/ID pipeline register and replaces the in-core `Mem[PC]` fetch. Taken branches resolved in EX arrive as a redirect that flushes the queue.

## Interface
- `DEPTH`, 4: FIFO entries, minimum 2. Full throughput requires DEPTH ≥ 3.
- `AW`, 10: instruction-memory word-address width.
- `RESET_PC`, 32'h0: first fetch address after reset.

Ports:
- `clk1` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: read request this cycle.
- `imem_addr` out AW: word address, equal to `pc[AW-1:0]`.
- `imem_rdata` in 32: read data, valid exactly 1 cycle after the request.
- `redirect` in 1: taken branch; flush the queue and restart fetch.
- `redirect_pc` in 32: branch target word address.
- `halt` in 1: stop issuing new requests while high.
- `id_valid` out 1: FIFO head valid.
- `id_ir` out 32: head instruction; 0 when empty.
- `id_npc` out 32: head fetch address + 1; 0 when empty.
- `id_ready` in 1: ID consumes the head when `id_valid` is also high.
- `occupancy` out clog2(DEPTH+1): entries currently held.

## Operation
- State:
  - `pc` (32b).
  - FIFO of {ir, npc} with read/write pointers and `count`.
  - `inflight` (1b): a request was issued last cycle.
  - `inflight_pc` (32b): address of that request.
- Request, combinational: `imem_req = rst_n & !redirect & !halt & (count + inflight < DEPTH)`.
  - On a request: `pc <= pc + 1` (32-bit wrap, 0xFFFFFFFF→0), `inflight <= 1`, `inflight_pc <= pc`. Otherwise `inflight <= 0`.
- Response: when `inflight` is 1 and no redirect, push {`imem_rdata`, `inflight_pc + 1`}. The credit rule guarantees no overflow.
- Pop: when `id_valid & id_ready` and no redirect.
  - Push and pop in the same cycle leave `count` unchanged.
  - There is no empty-bypass: a pushed word is visible to ID on the following cycle.
- Redirect has priority over every other event in its cycle:
  - `count`, pointers and `inflight` go to 0.
  - `pc <= redirect_pc`.
  - A response arriving in that cycle is dropped; a pop in that cycle is ignored.
  - `imem_req` is 0 during the redirect cycle.
- Halt: only gates new requests.
  - An in-flight response still completes and is pushed.
  - The FIFO still drains.
  - A redirect while halted still flushes and loads `pc`.
- Reset (asynchronous, mid-operation included):
  - `pc = RESET_PC`; `count`, pointers and `inflight` = 0; FIFO storage = 0.
  - `id_valid = 0`, `id_ir = 0`, `id_npc = 0`, `occupancy = 0`, `imem_req = 0`.
  - Any in-flight response is discarded.

## Timing
- Cold start: `imem_req` is high in the first cycle after `rst_n` rises; `id_valid` rises 2 edges later.
- Redirect latency: redirect sampled at edge E0 → request for the target in the cycle after E0 → data at E1 → `id_valid` with the target after E2.
- Steady state, DEPTH ≥ 3 with `id_ready` held high: one instruction per cycle, `occupancy` = 1.
- Backpressure: with `id_ready` low, requests stop once `count + inflight == DEPTH`, leaving `occupancy == DEPTH`. Fetch resumes in the cycle after the first pop.
- `id_valid`, `id_ir`, `id_npc` and `occupancy` are registered-state driven (FIFO head and count); there is no combinational path from `id_ready` or `imem_rdata`.

## Test plan
- **Reset and cold start:** RESET_PC=0, memory word k = 0x1000+k, `id_ready` = 1.
  - `id_valid` first high 2 cycles after reset release, with ir=0x1000, npc=1.
  - Then one instruction per cycle: 0x1001 (npc 2), 0x1002 (npc 3), …
- **Backpressure fill/drain:** DEPTH=4, `id_ready` = 0.
  - `imem_req` issues exactly 4 requests, then `occupancy` = 4 and `imem_req` stays 0.
  - Raise `id_ready` → entries pop in order 0x1000..0x1003 and fetch resumes at address 4 with no lost or duplicated word.
- **Redirect mid-stream:** assert `redirect` with `redirect_pc` = 0x40 while `occupancy` = 2 and a response is in flight.
  - Next cycle `occupancy` = 0 and `id_valid` = 0.
  - 2 edges later the head is ir=0x1040, npc=0x41.
  - The dropped response never appears.
- **Redirect + pop + response in one cycle:** pop and response are both discarded; `occupancy` = 0 afterwards.
- **Halt:** raise `halt` with one request in flight and `id_ready` = 0.
  - That word is still pushed and no further `imem_req` is issued.
  - Dropping `halt` resumes fetch at the next sequential address.
- **Reset mid-operation and wrap:**
  - `occupancy` = 3, then pull `rst_n` low asynchronously → all outputs 0 immediately; restart at RESET_PC.
  - Separately, redirect to 0xFFFFFFFF → npc of that entry is 0x00000000 and the next fetch address is 0.
